stack_ctrl: RTL

- Push/pop sequencer that drives the register bank's read port, write port and SP increment/decrement (`incdec`) interface, plus a single-beat data-memory port.
- Register 16 is the stack pointer.
- A push copies a GPR to memory at SP-4, then decrements SP by 4. A pop loads memory at SP into a GPR, then increments SP by 4.
- Sits between the control unit and the register bank / data memory.

---
 rtl/stack_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/stack_ctrl.sv
// Push/pop sequencer between the control unit, the register bank (r16 = SP) and a
// single-beat data memory. One operation in flight; the bank applies SP changes via incdec.
module stack_ctrl #(
    parameter int unsigned STACK_TOP   = 900,
    parameter int unsigned STACK_LIMIT = 512,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        push,
    input  logic        pop,
    input  logic [4:0]  reg_sel,
    input  logic [31:0] sp_in,
    output logic [4:0]  rf_rd,
    output logic        rf_re,
    input  logic [31:0] rf_rdata,
    output logic [4:0]  rf_wr,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    output logic [1:0]  incdec,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        done,
    output logic [1:0]  err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_OVF    = 2'd1;
    localparam logic [1:0] ERR_UNF    = 2'd2;
    localparam logic [1:0] ERR_TMO    = 2'd3;
    localparam logic [1:0] INCDEC_INC = 2'b01;
    localparam logic [1:0] INCDEC_DEC = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDREG,
        S_MEMWR,
        S_MEMRD,
        S_WB,
        S_SPUPD,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_is_push;
    logic [4:0]        r_reg_sel;
    logic [31:0]       r_sp_q;
    logic [31:0]       r_wdata_q;
    logic [31:0]       r_rdata_q;
    logic [1:0]        r_err_code;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept;
    logic              w_push_ovf;
    logic              w_pop_unf;
    logic              w_limit;
    logic              w_in_mem;

    // req_ready is gated by rst_n so it reads low for the whole reset, not just after the first edge.
    assign req_ready  = rst_n && (r_state == S_IDLE);
    assign w_accept   = req_valid && req_ready && (push || pop);
    assign w_push_ovf = ({1'b0, sp_in} < (33'(STACK_LIMIT) + 33'd4));
    assign w_pop_unf  = (sp_in >= 32'(STACK_TOP));
    assign w_limit    = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_in_mem   = (r_state == S_MEMWR) || (r_state == S_MEMRD);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output and the next state get a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        rf_rd       = '0;
        rf_re       = 1'b0;
        rf_wr       = '0;
        rf_we       = 1'b0;
        rf_wdata    = '0;
        incdec      = 2'b00;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        done        = 1'b0;
        err         = ERR_NONE;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (push) begin
                        w_state_nxt = w_push_ovf ? S_ERR : S_RDREG;
                    end else begin
                        w_state_nxt = w_pop_unf ? S_ERR : S_MEMRD;
                    end
                end
            end
            S_RDREG: begin
                rf_re       = 1'b1;
                rf_rd       = r_reg_sel;
                w_state_nxt = S_MEMWR;
            end
            S_MEMWR: begin
                mem_we    = 1'b1;
                mem_addr  = r_sp_q - 32'd4;
                mem_wdata = r_wdata_q;
                // An ack on the limit cycle still completes normally.
                if (mem_ack) begin
                    w_state_nxt = S_SPUPD;
                end else if (w_limit) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_MEMRD: begin
                mem_re   = 1'b1;
                mem_addr = r_sp_q;
                if (mem_ack) begin
                    w_state_nxt = S_WB;
                end else if (w_limit) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_WB: begin
                rf_we       = 1'b1;
                rf_wr       = r_reg_sel;
                rf_wdata    = r_rdata_q;
                w_state_nxt = S_SPUPD;
            end
            S_SPUPD: begin
                incdec      = r_is_push ? INCDEC_DEC : INCDEC_INC;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                done        = 1'b1;
                err         = r_err_code;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_push  <= 1'b0;
            r_reg_sel  <= '0;
            r_sp_q     <= '0;
            r_wdata_q  <= '0;
            r_rdata_q  <= '0;
            r_err_code <= ERR_NONE;
            r_cnt      <= '0;
        end else begin
            if (w_accept) begin
                r_is_push  <= push;
                r_reg_sel  <= reg_sel;
                r_sp_q     <= sp_in;
                r_err_code <= push ? (w_push_ovf ? ERR_OVF : ERR_NONE)
                                   : (w_pop_unf  ? ERR_UNF : ERR_NONE);
            end

            if (r_state == S_RDREG) begin
                r_wdata_q <= rf_rdata;
            end

            if ((r_state == S_MEMRD) && mem_ack) begin
                r_rdata_q <= mem_rdata;
            end

            if (w_in_mem && !mem_ack && w_limit) begin
                r_err_code <= ERR_TMO;
            end

            // Counter sits at zero outside the memory states, so it is clear on entry.
            if (!w_in_mem) begin
                r_cnt <= '0;
            end else if (!mem_ack) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
